// File: rtl/sw_led_pkg.sv
// rtl/sw_led_pkg.sv - shared sizes and group helper for the switch/LED block
package sw_led_pkg;

  localparam int NUM_GROUPS  = 4;
  localparam int GROUP_WIDTH = 4;
  localparam int NUM_SW      = NUM_GROUPS * GROUP_WIDTH;
  localparam int SYNC_STAGES = 2;

  function automatic int grp_of(input int idx);
    return idx / GROUP_WIDTH;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - 2-FF synchronizer plus symmetric debounce for one push button
module btn_debounce
  import sw_led_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic din_async,
  output logic dout
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;

  logic [SYNC_STAGES-1:0] sync;
  logic [CW-1:0]          cnt;
  logic                   synced;

  assign synced = sync[SYNC_STAGES-1];

  // Any cycle of agreement restarts the count, so only a sustained change is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= '0;
      cnt  <= '0;
      dout <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], din_async};
      if (synced == dout) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        dout <= synced;
        cnt  <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/sw_led_ctrl.sv
// rtl/sw_led_ctrl.sv - synchronized switch-to-LED mapping with per-group button blanking
module sw_led_ctrl
  import sw_led_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic sw0,  input  logic sw1,  input  logic sw2,  input  logic sw3,
  input  logic sw4,  input  logic sw5,  input  logic sw6,  input  logic sw7,
  input  logic sw8,  input  logic sw9,  input  logic sw10, input  logic sw11,
  input  logic sw12, input  logic sw13, input  logic sw14, input  logic sw15,
  input  logic push_button1,
  input  logic push_button2,
  input  logic push_button3,
  input  logic push_button4,
  output logic led0,  output logic led1,  output logic led2,  output logic led3,
  output logic led4,  output logic led5,  output logic led6,  output logic led7,
  output logic led8,  output logic led9,  output logic led10, output logic led11,
  output logic led12, output logic led13, output logic led14, output logic led15
);

  logic [NUM_SW-1:0]     sw;
  logic [NUM_SW-1:0]     sw_s1;
  logic [NUM_SW-1:0]     sw_s2;
  logic [NUM_SW-1:0]     mask;
  logic [NUM_SW-1:0]     led;
  logic [NUM_GROUPS-1:0] btn;
  logic [NUM_GROUPS-1:0] btn_db;

  assign sw  = {sw15, sw14, sw13, sw12, sw11, sw10, sw9, sw8,
                sw7, sw6, sw5, sw4, sw3, sw2, sw1, sw0};
  assign btn = {push_button4, push_button3, push_button2, push_button1};

  for (genvar g = 0; g < NUM_GROUPS; g++) begin : g_btn
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk       (clk),
      .rst       (rst),
      .din_async (btn[g]),
      .dout      (btn_db[g])
    );
  end

  always_comb begin
    mask = '0;
    for (int i = 0; i < NUM_SW; i++) begin
      mask[i] = btn_db[grp_of(i)];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sw_s1 <= '0;
      sw_s2 <= '0;
      led   <= '0;
    end else begin
      sw_s1 <= sw;
      sw_s2 <= sw_s1;
      led   <= sw_s2 & ~mask;
    end
  end

  assign {led15, led14, led13, led12, led11, led10, led9, led8,
          led7, led6, led5, led4, led3, led2, led1, led0} = led;

endmodule

// File: tb/tb_sw_led_ctrl.sv
// tb/tb_sw_led_ctrl.sv - scoreboard bench for sw_led_ctrl
module tb_sw_led_ctrl;

  localparam int DB = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] sw_v = '0;
  logic [3:0]  btn_v = '0;
  logic [15:0] led_v;

  int errors = 0;
  int checks = 0;

  logic [15:0] sb[$];
  logic [15:0] exp_v;

  logic [15:0] m_s1, m_s2, m_led;
  logic [3:0]  m_b1, m_b2, m_d;
  int          m_run[4];

  always #5 clk = ~clk;

  sw_led_ctrl #(.DEBOUNCE_CYCLES(DB)) dut (
    .clk(clk), .rst(rst),
    .sw0(sw_v[0]),   .sw1(sw_v[1]),   .sw2(sw_v[2]),   .sw3(sw_v[3]),
    .sw4(sw_v[4]),   .sw5(sw_v[5]),   .sw6(sw_v[6]),   .sw7(sw_v[7]),
    .sw8(sw_v[8]),   .sw9(sw_v[9]),   .sw10(sw_v[10]), .sw11(sw_v[11]),
    .sw12(sw_v[12]), .sw13(sw_v[13]), .sw14(sw_v[14]), .sw15(sw_v[15]),
    .push_button1(btn_v[0]), .push_button2(btn_v[1]),
    .push_button3(btn_v[2]), .push_button4(btn_v[3]),
    .led0(led_v[0]),   .led1(led_v[1]),   .led2(led_v[2]),   .led3(led_v[3]),
    .led4(led_v[4]),   .led5(led_v[5]),   .led6(led_v[6]),   .led7(led_v[7]),
    .led8(led_v[8]),   .led9(led_v[9]),   .led10(led_v[10]), .led11(led_v[11]),
    .led12(led_v[12]), .led13(led_v[13]), .led14(led_v[14]), .led15(led_v[15])
  );

  // Reference pipeline: LED from previous-edge state, debounce as a disagreement run length.
  task automatic model_edge(input logic [15:0] s, input logic [3:0] b, input logic r);
    if (r) begin
      m_s1 = '0; m_s2 = '0; m_b1 = '0; m_b2 = '0; m_d = '0; m_led = '0;
      for (int g = 0; g < 4; g++) m_run[g] = 0;
    end else begin
      for (int i = 0; i < 16; i++) m_led[i] = m_s2[i] & ~m_d[i/4];
      for (int g = 0; g < 4; g++) begin
        if (m_b2[g] !== m_d[g]) begin
          m_run[g] = m_run[g] + 1;
          if (m_run[g] == DB) begin
            m_d[g]   = m_b2[g];
            m_run[g] = 0;
          end
        end else begin
          m_run[g] = 0;
        end
      end
      m_s2 = m_s1; m_s1 = s;
      m_b2 = m_b1; m_b1 = b;
    end
  endtask

  task automatic cycle(input logic [15:0] s, input logic [3:0] b, input logic r);
    @(negedge clk);
    sw_v = s; btn_v = b; rst = r;
    @(posedge clk);
    model_edge(s, b, r);
    sb.push_back(m_led);
    #1;
  endtask

  task automatic test_reset;
    for (int c = 0; c < 3; c++) begin
      cycle(16'hFFFF, 4'hF, 1'b1);
      exp_v = sb.pop_front();
      checks++;
      if (led_v !== 16'h0000) begin
        errors++;
        $display("FAIL reset_hold c=%0d: led=%h expected 0000", c, led_v);
      end
    end
    for (int c = 1; c <= 10; c++) begin
      cycle(16'hFFFF, 4'hF, 1'b0);
      exp_v = sb.pop_front();
      checks++;
      if (led_v !== exp_v) begin
        errors++;
        $display("FAIL reset_release sb c=%0d: led=%h expected %h", c, led_v, exp_v);
      end
      if (c == 2 || c == 3 || c == 6 || c == 7) begin
        checks++;
        if (led_v !== ((c == 3 || c == 6) ? 16'hFFFF : 16'h0000)) begin
          errors++;
          $display("FAIL reset_release edge=%0d: led=%h", c, led_v);
        end
      end
    end
  endtask

  task automatic settle(input logic [15:0] s, input logic [3:0] b);
    for (int c = 0; c < 12; c++) begin
      cycle(s, b, 1'b0);
      exp_v = sb.pop_front();
      checks++;
      if (led_v !== exp_v) begin
        errors++;
        $display("FAIL settle c=%0d: led=%h expected %h", c, led_v, exp_v);
      end
    end
  endtask

  task automatic test_passthrough;
    logic [15:0] pat;
    settle(16'h0000, 4'h0);
    for (int p = 0; p < 2; p++) begin
      pat = (p == 0) ? 16'hA5C3 : 16'h0000;
      for (int c = 1; c <= 4; c++) begin
        cycle(pat, 4'h0, 1'b0);
        exp_v = sb.pop_front();
        checks++;
        if (led_v !== exp_v) begin
          errors++;
          $display("FAIL passthrough sb c=%0d: led=%h expected %h", c, led_v, exp_v);
        end
        if (c == 2 || c == 3) begin
          checks++;
          if (led_v !== ((c == 3) ? pat : ~pat & 16'hA5C3)) begin
            errors++;
            $display("FAIL passthrough latency c=%0d: led=%h pat=%h", c, led_v, pat);
          end
        end
      end
    end
  endtask

  task automatic test_group_blank;
    logic [3:0] b;
    settle(16'hFFFF, 4'h0);
    for (int p = 0; p < 2; p++) begin
      b = (p == 0) ? 4'b0100 : 4'b0000;
      for (int c = 1; c <= 9; c++) begin
        cycle(16'hFFFF, b, 1'b0);
        exp_v = sb.pop_front();
        checks++;
        if (led_v !== exp_v) begin
          errors++;
          $display("FAIL group_blank sb c=%0d: led=%h expected %h", c, led_v, exp_v);
        end
        if (c == 6 || c == 7) begin
          checks++;
          if (led_v !== (((c == 7) == (p == 0)) ? 16'hF0FF : 16'hFFFF)) begin
            errors++;
            $display("FAIL group_blank p=%0d c=%0d: led=%h", p, c, led_v);
          end
        end
      end
    end
  endtask

  task automatic test_glitch;
    settle(16'hFFFF, 4'h0);
    for (int c = 0; c < 14; c++) begin
      cycle(16'hFFFF, (c < 3) ? 4'b0001 : 4'b0000, 1'b0);
      exp_v = sb.pop_front();
      checks++;
      if (led_v !== 16'hFFFF || exp_v !== 16'hFFFF) begin
        errors++;
        $display("FAIL glitch c=%0d: led=%h model=%h expected ffff", c, led_v, exp_v);
      end
    end
  endtask

  task automatic test_multi_reset;
    settle(16'hFFFF, 4'hF);
    checks++;
    if (led_v !== 16'h0000) begin
      errors++;
      $display("FAIL multi_hold: led=%h expected 0000", led_v);
    end
    cycle(16'hFFFF, 4'hF, 1'b1);
    exp_v = sb.pop_front();
    checks++;
    if (led_v !== 16'h0000) begin
      errors++;
      $display("FAIL multi_reset: led=%h expected 0000", led_v);
    end
    for (int c = 1; c <= 9; c++) begin
      cycle(16'hFFFF, 4'hF, 1'b0);
      exp_v = sb.pop_front();
      checks++;
      if (led_v !== exp_v) begin
        errors++;
        $display("FAIL multi_release sb c=%0d: led=%h expected %h", c, led_v, exp_v);
      end
      if (c == 3 || c == 7) begin
        checks++;
        if (led_v !== ((c == 3) ? 16'hFFFF : 16'h0000)) begin
          errors++;
          $display("FAIL multi_release edge=%0d: led=%h", c, led_v);
        end
      end
    end
  endtask

  task automatic test_random;
    logic [3:0] b = '0;
    int hold[4];
    int bad = 0;
    for (int g = 0; g < 4; g++) hold[g] = 0;
    for (int c = 0; c < 1000; c++) begin
      for (int g = 0; g < 4; g++) begin
        if (hold[g] == 0) begin
          b[g]    = $urandom_range(0, 1);
          hold[g] = $urandom_range(1, 10);
        end
        hold[g]--;
      end
      cycle(16'($urandom), b, 1'b0);
      exp_v = sb.pop_front();
      checks++;
      if (led_v !== exp_v) begin
        errors++;
        bad++;
        if (bad <= 10) $display("FAIL random c=%0d: led=%h expected %h", c, led_v, exp_v);
      end
    end
  endtask

  initial begin
    model_edge('0, '0, 1'b1);
    test_reset();
    test_passthrough();
    test_group_blank();
    test_glitch();
    test_multi_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
